// File: rtl/mash_pkg.sv
// mash_pkg: shared constants and the order type for the MASH modulator
package mash_pkg;
  localparam int OUT_WIDTH = 4;
  localparam logic [15:0] LFSR_SEED = 16'hACE1;
  localparam logic [15:0] LFSR_TAPS = 16'hB400;
  typedef enum logic [1:0] {ORDER_1 = 2'd1, ORDER_2 = 2'd2, ORDER_3 = 2'd3} order_t;
endpackage

// File: rtl/mash_lfsr.sv
// mash_lfsr: 16-bit Galois LFSR dither source, advances on request
module mash_lfsr
  import mash_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic adv,
  output logic q
);
  logic [15:0] lfsr;
  always_ff @(posedge clk or posedge rst)
    if (rst) lfsr <= LFSR_SEED;
    else if (adv) lfsr <= (lfsr >> 1) ^ (lfsr[0] ? LFSR_TAPS : 16'h0000);
  assign q = lfsr[0];
endmodule

// File: rtl/axis_mash.sv
// axis_mash: MASH 1-1-1 sigma-delta modulator with AXI-stream in/out
module axis_mash
  import mash_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int ORDER = 3
) (
  input  logic                 aclk,
  input  logic                 arst,
  input  logic [WIDTH-1:0]     s_axis_data_tdata,
  input  logic                 s_axis_data_tvalid,
  output logic                 s_axis_data_tready,
  output logic [OUT_WIDTH-1:0] m_axis_data_tdata,
  output logic                 m_axis_data_tvalid,
  input  logic                 m_axis_data_tready,
  input  logic [1:0]           order_sel,
  input  logic                 dither_enable
);
  localparam order_t ORD_MAX = order_t'(ORDER);
  order_t ord, ord_sel;
  logic up, change, acc, lfsr_bit, act2, act3, c2, c3, c2p, c3p, c3pp;
  logic [WIDTH-1:0] e1, e2, e3;
  logic [WIDTH:0] s1, s2, s3;
  logic [OUT_WIDTH-1:0] y;
  assign ord_sel = (order_sel == 2'd0 || order_sel > ORD_MAX) ? ORD_MAX : order_t'(order_sel);
  assign change = ord_sel != ord;
  assign s_axis_data_tready = up && !change && (!m_axis_data_tvalid || m_axis_data_tready);
  assign acc = s_axis_data_tvalid && s_axis_data_tready;
  mash_lfsr u_lfsr (.clk(aclk), .rst(arst), .adv(acc), .q(lfsr_bit));
  assign act2 = ord >= ORDER_2;
  assign act3 = ord >= ORDER_3;
  // each stage integrates the freshly updated residue of the one below
  assign s1 = {1'b0, e1} + {1'b0, s_axis_data_tdata} + (WIDTH+1)'(dither_enable & lfsr_bit);
  assign s2 = {1'b0, e2} + {1'b0, s1[WIDTH-1:0]};
  assign s3 = {1'b0, e3} + {1'b0, s2[WIDTH-1:0]};
  assign c2 = act2 & s2[WIDTH];
  assign c3 = act3 & s3[WIDTH];
  // modular 4-bit sum is exact: the result always fits -3..4
  assign y = OUT_WIDTH'(s1[WIDTH]) + OUT_WIDTH'(c2) - OUT_WIDTH'(c2p)
           + OUT_WIDTH'(c3) - OUT_WIDTH'({c3p, 1'b0}) + OUT_WIDTH'(c3pp);
  always_ff @(posedge aclk or posedge arst)
    if (arst) begin
      up <= 1'b0;
      ord <= ORD_MAX;
      e1 <= '0;
      e2 <= '0;
      e3 <= '0;
      c2p <= 1'b0;
      c3p <= 1'b0;
      c3pp <= 1'b0;
    end else begin
      up <= 1'b1;
      if (change) begin
        ord <= ord_sel;
        e1 <= '0;
        e2 <= '0;
        e3 <= '0;
        c2p <= 1'b0;
        c3p <= 1'b0;
        c3pp <= 1'b0;
      end else if (acc) begin
        e1 <= s1[WIDTH-1:0];
        e2 <= act2 ? s2[WIDTH-1:0] : '0;
        e3 <= act3 ? s3[WIDTH-1:0] : '0;
        c2p <= c2;
        c3p <= c3;
        c3pp <= c3p;
      end
    end
  always_ff @(posedge aclk or posedge arst)
    if (arst) begin
      m_axis_data_tdata <= '0;
      m_axis_data_tvalid <= 1'b0;
    end else if (acc) begin
      m_axis_data_tdata <= y;
      m_axis_data_tvalid <= 1'b1;
    end else if (m_axis_data_tready) begin
      m_axis_data_tvalid <= 1'b0;
    end
endmodule

// File: tb/tb_axis_mash.sv
// tb_axis_mash: directed self-checking bench for axis_mash
module tb_axis_mash;
  logic aclk = 1'b0, arst = 1'b1;
  logic [15:0] s_tdata = '0;
  logic s_valid = 1'b0, s_ready, m_valid, m_ready = 1'b1, dither = 1'b0;
  logic [3:0] m_tdata;
  logic [1:0] order_sel = 2'd3;
  int total = 0, bad = 0;
  int m_e1, m_e2, m_e3, m_c2p, m_c3p, m_c3pp, m_lf;
  int q[$];

  axis_mash #(.WIDTH(16), .ORDER(3)) dut (
    .aclk(aclk), .arst(arst),
    .s_axis_data_tdata(s_tdata), .s_axis_data_tvalid(s_valid), .s_axis_data_tready(s_ready),
    .m_axis_data_tdata(m_tdata), .m_axis_data_tvalid(m_valid), .m_axis_data_tready(m_ready),
    .order_sel(order_sel), .dither_enable(dither)
  );

  always #5 aclk = ~aclk;

  task automatic chk(input string tag, input int got, input int want);
    total++;
    assert (got === want) else begin
      bad++;
      $error("FAIL %s got=%0d want=%0d", tag, got, want);
    end
  endtask

  task automatic mreset();
    m_e1 = 0; m_e2 = 0; m_e3 = 0; m_c2p = 0; m_c3p = 0; m_c3pp = 0;
  endtask

  task automatic mstep(input int x, input int o, input bit dith, output int y);
    int s, c1, c2, c3;
    c2 = 0; c3 = 0;
    s = m_e1 + x + (dith ? (m_lf & 1) : 0);
    c1 = s >> 16; m_e1 = s & 'hFFFF;
    if (o >= 2) begin s = m_e2 + m_e1; c2 = s >> 16; m_e2 = s & 'hFFFF; end
    if (o >= 3) begin s = m_e3 + m_e2; c3 = s >> 16; m_e3 = s & 'hFFFF; end
    y = c1 + c2 - m_c2p + c3 - 2 * m_c3p + m_c3pp;
    m_c3pp = m_c3p; m_c3p = c3; m_c2p = c2;
    m_lf = (m_lf & 1) ? ((m_lf >> 1) ^ 'hB400) : (m_lf >> 1);
  endtask

  task automatic push(input logic [15:0] x, output int y);
    s_tdata = x; s_valid = 1'b1; m_ready = 1'b1;
    #1;
    chk("push_rdy", int'(s_ready), 1);
    @(posedge aclk); #1;
    chk("push_vld", int'(m_valid), 1);
    y = int'($signed(m_tdata));
  endtask

  task automatic push_model(input logic [15:0] x, input int o, input bit dith, input string tag);
    int y, ye;
    mstep(int'(x), o, dith, ye);
    push(x, y);
    chk(tag, y, ye);
  endtask

  task automatic set_order(input logic [1:0] o);
    order_sel = o; s_valid = 1'b1; s_tdata = 16'hFFFF; m_ready = 1'b1;
    #1;
    chk("chg_rdy_low", int'(s_ready), 0);
    @(posedge aclk); #1;
    chk("chg_rdy_high", int'(s_ready), 1);
  endtask

  initial begin
    int y, sum, ins, outs, held, d;
    repeat (3) @(posedge aclk);
    #1;
    chk("rst_rdy", int'(s_ready), 0);
    chk("rst_vld", int'(m_valid), 0);
    chk("rst_dat", int'(m_tdata), 0);
    arst = 1'b0;
    @(posedge aclk); #1;
    chk("rdy_after_rst", int'(s_ready), 1);
    // zero input, order 3
    for (int i = 0; i < 100; i++) begin push(16'h0000, y); chk("o3_zero", y, 0); end
    // half scale, order 1: alternating 0,1
    set_order(2'd1);
    for (int i = 0; i < 8; i++) begin push(16'h8000, y); chk("o1_alt", y, i % 2); end
    // quarter scale, order 2: bounded output, mean 1/4
    set_order(2'd2);
    sum = 0;
    for (int n = 1; n <= 4096; n++) begin
      push(16'h4000, y);
      chk("o2_range", int'(y >= -1 && y <= 2), 1);
      sum += y;
      d = 4 * sum - n;
      chk("o2_run", int'(d >= -8 && d <= 8), 1);
    end
    chk("o2_total", sum, 1024);
    // downstream stall with continuous input, order 3
    set_order(2'd3);
    mreset();
    ins = 0; outs = 0; held = 0;
    for (int i = 0; i < 40; i++) begin
      s_valid = 1'b1;
      s_tdata = 16'(32'h1234 + i * 32'h0777);
      m_ready = !(i >= 10 && i < 20);
      #1;
      if (i >= 10 && i < 20) chk("stall_rdy", int'(s_ready), 0);
      if (i == 10) begin chk("stall_vld", int'(m_valid), 1); held = int'(m_tdata); end
      if (i > 10 && i < 20) chk("stall_hold", int'(m_tdata), held);
      if (m_valid && m_ready) begin
        outs++;
        chk("stall_seq", int'($signed(m_tdata)), q.size() > 0 ? q.pop_front() : 99);
      end
      if (s_valid && s_ready) begin
        ins++;
        mstep(int'(s_tdata), 3, 1'b0, y);
        q.push_back(y);
      end
      @(posedge aclk); #1;
    end
    s_valid = 1'b0; m_ready = 1'b1;
    #1;
    if (m_valid) begin
      outs++;
      chk("stall_seq", int'($signed(m_tdata)), q.size() > 0 ? q.pop_front() : 99);
    end
    @(posedge aclk); #1;
    chk("stall_ins", ins, 30);
    chk("stall_outs", outs, ins);
    chk("stall_left", q.size(), 0);
    // mid-stream order change 3 -> 1
    for (int i = 0; i < 3; i++) push_model(16'(32'h2345 + i * 32'h1357), 3, 1'b0, "pre_chg");
    set_order(2'd1);
    mreset();
    for (int i = 0; i < 12; i++) push_model(16'(32'h3001 + i * 32'h1111), 1, 1'b0, "post_chg");
    // asynchronous reset mid-stream, then dithered order-3 run from power-up state
    for (int i = 0; i < 3; i++) push_model(16'h6000, 1, 1'b0, "pre_rst");
    s_valid = 1'b1;
    #2;
    arst = 1'b1;
    #1;
    chk("arst_vld", int'(m_valid), 0);
    chk("arst_rdy", int'(s_ready), 0);
    chk("arst_dat", int'(m_tdata), 0);
    order_sel = 2'd0; dither = 1'b1;
    @(posedge aclk); #1;
    arst = 1'b0; s_valid = 1'b0;
    @(posedge aclk); #1;
    chk("rearm_rdy", int'(s_ready), 1);
    mreset();
    m_lf = 'hACE1;
    for (int i = 0; i < 24; i++) push_model(16'(32'h1F3D + i * 32'h2B1), 3, 1'b1, "dith_o3");
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
